nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 5 +
 rtl/nibble_serial_adder_adder_4b.sv | 16 +
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared FSM state type and nibble width for the nibble-serial adder.
package nibble_serial_adder_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/nibble_serial_adder_adder_4b.sv
// adder_4b_ins: 4-bit ripple-carry adder used as the single nibble datapath.
module adder_4b_ins (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [4:0] c;
    assign c[0] = ci_i;
    for (genvar i = 0; i < 4; i++) begin : g_rc
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign co_o = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds/subtracts two WIDTH-bit operands one nibble per cycle, LSB first.
// Subtract mode is built only when NIBBLE_SERIAL_ADDER_SUB_EN is defined; otherwise sub is ignored.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int NN = WIDTH / NIBBLE_W;
    localparam int IW = $clog2(NN);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
    logic             c_nib, sub_eff, last;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign sub_eff = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
`endif

    assign a_nib = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[idx_q * NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
    assign last  = idx_q == IW'(NN - 1);

    adder_4b_ins u_add (
        .a_i  (a_nib),
        .b_i  (b_nib),
        .ci_i (carry_q),
        .s_o  (s_nib),
        .co_o (c_nib)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                sub_d   = sub_eff;
                carry_d = sub_eff;
                idx_d   = '0;
            end
            RUN: begin
                sum_d[idx_q * NIBBLE_W +: NIBBLE_W] = s_nib;
                carry_d = c_nib;
                // cout/overflow track every nibble; only the last one survives into DONE
                cout_d  = c_nib;
                ovf_d   = (a_nib[NIBBLE_W-1] ~^ b_nib[NIBBLE_W-1]) & (s_nib[NIBBLE_W-1] ^ a_nib[NIBBLE_W-1]);
                idx_d   = last ? '0 : idx_q + IW'(1);
                state_d = last ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = state_q == RUN;
    assign done     = state_q == DONE;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: scoreboard bench for nibble_serial_adder with directed and random operations.
module tb_nibble_serial_adder;
    localparam int WIDTH = 16;
    localparam int NN    = WIDTH / 4;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             busy, done, cout, overflow;
    logic [WIDTH-1:0] sum;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, n_vec = 0, n_err = 0, n_done = 0, busy_cnt = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss);
        exp_t             m;
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] be;
        logic             s;
        s     = SUB_EN && ss;
        be    = s ? ~bb : bb;
        r     = {1'b0, aa} + {1'b0, be} + (WIDTH + 1)'(s);
        m.sum = r[WIDTH-1:0];
        m.cout = r[WIDTH];
        m.ovf = (aa[WIDTH-1] == be[WIDTH-1]) && (r[WIDTH-1] != aa[WIDTH-1]);
        m.cyc = 0;
        return m;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) busy_cnt = 0;
        else begin
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done=1 with no pending operation (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_cnt), 32'(NN));
                    check("busy_in_done", 32'(busy), 32'(0));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss, input exp_t e);
        @(negedge clk);
        a = aa; b = bb; sub = ss; start = 1'b1;
        e.cyc = cyc + NN + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d operations still pending", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_exp(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic ss,
                           input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e = '{sum: es, cout: ec, ovf: eo, cyc: 0};
        issue(aa, bb, ss, e);
        wait_idle();
        check("sum_held", 32'(sum), 32'(es));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_sum"}, 32'(sum), 32'(0));
        check({tag, "_cout"}, 32'(cout), 32'(0));
        check({tag, "_ovf"}, 32'(overflow), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        logic [WIDTH-1:0] ra, rb;
        logic rs;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_exp(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_exp(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_exp(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        if (SUB_EN) run_exp(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        else        run_exp(16'h0005, 16'h0007, 1'b1, 16'h000C, 1'b0, 1'b0);

        // start pulses during RUN and during DONE must be dropped
        d0 = n_done;
        issue(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'(1));
        a = 16'h0F0F; b = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("ignore_done_count", 32'(n_done - d0), 32'(1));
        check("ignore_sum", 32'(sum), 32'h3333);
        check("ignore_busy", 32'(busy), 32'(0));
        check("ignore_pending", 32'(q.size()), 32'(0));

        // asynchronous reset in the second RUN cycle aborts without done
        issue(16'h1234, 16'h4321, 1'b0, model(16'h1234, 16'h4321, 1'b0));
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        d0 = n_done;
        #1;
        check_zero("abort");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'(0));
        run_exp(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'hFFFF;
            issue(ra, rb, rs, model(ra, rb, rs));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
